// File: rtl/pipe_skid_reg_pkg.sv
// Shared width and state encoding for the elastic pipeline register.
// Imported by the control block and the data-holding flops.
package pipe_skid_reg_pkg;

  localparam int WORD = 64;

  typedef enum logic [1:0] {
    PSR_EMPTY = 2'b00,
    PSR_BUSY  = 2'b01,
    PSR_FULL  = 2'b10
  } psr_state_t;

  function automatic logic [1:0] psr_occupancy(input psr_state_t state);
    case (state)
      PSR_BUSY: return 2'd1;
      PSR_FULL: return 2'd2;
      default:  return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/pipe_skid_reg_dffe.sv
// D flip-flop with load enable and asynchronous active-low clear.
// Holds one payload entry of the skid register.
module pipe_skid_reg_dffe #(
  parameter int SIZE = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic [SIZE-1:0] d,
  output logic [SIZE-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/pipe_skid_reg.sv
// Two-entry elastic pipeline register with flush; in_ready depends only on
// the state register, so there is no combinational path from out_ready.
module pipe_skid_reg
  import pipe_skid_reg_pkg::*;
#(
  parameter int SIZE = WORD
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [SIZE-1:0] in_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [SIZE-1:0] out_data,
  output logic [1:0]      occupancy
);

  psr_state_t      state_reg;
  psr_state_t      state_next;
  logic            push;
  logic            pop;
  logic            main_en;
  logic            main_from_skid;
  logic            skid_en;
  logic [SIZE-1:0] main_d;
  logic [SIZE-1:0] main_q;
  logic [SIZE-1:0] skid_q;

  assign in_ready  = (state_reg != PSR_FULL);
  assign out_valid = (state_reg != PSR_EMPTY);
  assign out_data  = main_q;
  assign occupancy = psr_occupancy(state_reg);

  assign push = in_valid & in_ready;
  assign pop  = out_valid & out_ready;

  always_comb begin
    state_next     = state_reg;
    main_en        = 1'b0;
    main_from_skid = 1'b0;
    skid_en        = 1'b0;
    // Flush wins outright: any push is dropped and the data flops keep
    // their stale contents, which out_valid=0 masks downstream.
    if (flush) begin
      state_next = PSR_EMPTY;
    end else begin
      case (state_reg)
        PSR_EMPTY: begin
          if (push) begin
            state_next = PSR_BUSY;
            main_en    = 1'b1;
          end
        end
        PSR_BUSY: begin
          if (push && !pop) begin
            state_next = PSR_FULL;
            skid_en    = 1'b1;
          end else if (push && pop) begin
            main_en    = 1'b1;
          end else if (pop) begin
            state_next = PSR_EMPTY;
          end
        end
        PSR_FULL: begin
          if (pop) begin
            state_next     = PSR_BUSY;
            main_en        = 1'b1;
            main_from_skid = 1'b1;
          end
        end
        default: state_next = PSR_EMPTY;
      endcase
    end
  end

  assign main_d = main_from_skid ? skid_q : in_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= PSR_EMPTY;
    end else begin
      state_reg <= state_next;
    end
  end

  pipe_skid_reg_dffe #(.SIZE(SIZE)) u_main (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (main_en),
    .d     (main_d),
    .q     (main_q)
  );

  pipe_skid_reg_dffe #(.SIZE(SIZE)) u_skid (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (skid_en),
    .d     (in_data),
    .q     (skid_q)
  );

endmodule

// File: doc/pipe_skid_reg.md
Name: pipe_skid_reg

Overview:
- Elastic pipeline register between LEGv8 pipeline stages, e.g. IF to ID and ID to EX.
- Replaces a bare D flip-flop stage wherever backpressure (stall) and flush are required.
- Two-entry skid buffer with a valid/ready handshake on both sides.
- Sustains 1 transfer/cycle; in_ready is purely registered-state-driven, so there is no combinational ready path from out_ready.

Parameters:
SIZE, `WORD (64), payload width in bits

Ports:
clk        input   1     clock, rising edge
rst_n      input   1     asynchronous reset, active-low
flush      input   1     synchronous pipeline flush (branch taken / exception)
in_valid   input   1     upstream has data
in_ready   output  1     block can accept data this cycle
in_data    input   SIZE  upstream payload
out_valid  output  1     out_data valid
out_ready  input   1     downstream accepts this cycle
out_data   output  SIZE  payload to downstream
occupancy  output  2     number of entries held: 0, 1 or 2

Behaviour:
- Reset: rst_n, asynchronous, active-low; clock clk.
  - While rst_n=0: state=EMPTY, main_data=0, skid_data=0.
  - Outputs during reset: out_valid=0, out_data=0, occupancy=0, in_ready=1.
- Events:
  - push = in_valid & in_ready.
  - pop = out_valid & out_ready.
- Outputs decoded from the state register only:
  - in_ready = (state != FULL).
  - out_valid = (state != EMPTY).
  - out_data = main_data.
  - occupancy: EMPTY=0, BUSY=1, FULL=2.
- States:
  - EMPTY: main invalid.
  - BUSY: main valid, skid empty.
  - FULL: main valid, skid valid.
- Transitions (evaluated each rising clk):
  - flush=1, any state -> EMPTY.
    - Highest priority; a simultaneous push is dropped.
    - A simultaneous pop still counts as consumed downstream.
    - Data registers hold their values.
  - EMPTY, push -> BUSY, main_data<=in_data.
  - EMPTY, no push -> EMPTY.
  - BUSY, push & ~pop -> FULL, skid_data<=in_data.
  - BUSY, push & pop -> BUSY, main_data<=in_data.
  - BUSY, ~push & pop -> EMPTY.
  - BUSY, neither -> BUSY, hold.
  - FULL (in_ready=0, push impossible), pop -> BUSY, main_data<=skid_data.
  - FULL, ~pop -> FULL, hold.
- Latency: data pushed in cycle N is visible on out_data in cycle N+1 when the block was EMPTY, or when BUSY with a simultaneous pop.
- Ordering: strict FIFO; no data is duplicated or lost except on flush.
- Stability: out_data and out_valid are stable while out_valid=1 & out_ready=0.
- After a flush, out_data retains the stale main_data value; consumers qualify with out_valid.
- in_data is ignored when in_valid=0.
- Reset asserted mid-transfer: all entries are discarded immediately (asynchronous); no pop/push is reported in that cycle.
- Illegal state encoding recovers to EMPTY.

Decomposition:
- common.vh provides `WORD and the state encodings:
  - PSR_EMPTY=2'b00
  - PSR_BUSY=2'b01
  - PSR_FULL=2'b10
- One sub-module is natural: dffe (D flip-flop with enable, SIZE param, async active-low reset to 0).
  - Instantiated twice, for main_data and skid_data.
  - Enables come from the next-state logic.
- State/control logic stays in pipe_skid_reg.

Test Plan:
- Reset then idle: rst_n=0 -> in_ready=1, out_valid=0, out_data=0, occupancy=0; release with in_valid=0 for 5 cycles -> outputs unchanged.
- Streaming: out_ready=1, push 0x11,0x22,0x33 on consecutive cycles -> out_data 0x11,0x22,0x33 on cycles N+1..N+3, occupancy=1 throughout, in_ready=1.
- Backpressure fill: out_ready=0, push 0xA0,0xB0,0xC0 offered -> 0xA0,0xB0 accepted, occupancy=2, in_ready=0 while 0xC0 waits; out_ready=1 -> 0xA0,0xB0,0xC0 emerge in order with no gap after the first pop.
- Flush priority: FULL (0x1,0x2) with flush=1, in_valid=1 (0x3), out_ready=0 -> next cycle out_valid=0, occupancy=0, in_ready=1; 0x3 never appears.
- Simultaneous push/pop in BUSY: main=0x55, push 0x66 with out_ready=1 -> next cycle out_data=0x66, occupancy=1, in_ready=1.
- Async reset mid-operation: FULL state, drop rst_n between clock edges -> out_valid=0 and occupancy=0 without waiting for clk; after release, the first push of 0x77 emerges alone.
